// File: rtl/ball_motion.sv
// ball_motion: per-ball kinematics. Captures a new velocity, integrates it
// into a fixed-point position once per frame, applies periodic friction
// decay and reflects off the table cushions.
module ball_motion #(
    parameter int INIT_X          = 320,
    parameter int INIT_Y          = 240,
    parameter int X_MIN           = 32,
    parameter int X_MAX           = 592,
    parameter int Y_MIN           = 32,
    parameter int Y_MAX           = 432,
    parameter int FRICTION_PERIOD = 4,
    parameter int FRAC_BITS       = 6
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               velocityWriteEnable,
    input  logic signed [10:0] inVelocityX,
    input  logic signed [10:0] inVelocityY,
    input  logic               positionLoad,
    input  logic signed [10:0] inPositionX,
    input  logic signed [10:0] inPositionY,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic signed [10:0] velocityX,
    output logic signed [10:0] velocityY,
    output logic               moving,
    output logic               stoppedPulse
);

    localparam int POS_W = 11 + FRAC_BITS;
    // One extra bit so pos + v never wraps, even from an unclamped load.
    localparam int SUM_W = POS_W + 1;
    localparam int CNT_W = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;

    localparam logic signed [SUM_W-1:0] X_LO = SUM_W'(X_MIN * (2 ** FRAC_BITS));
    localparam logic signed [SUM_W-1:0] X_HI = SUM_W'(X_MAX * (2 ** FRAC_BITS));
    localparam logic signed [SUM_W-1:0] Y_LO = SUM_W'(Y_MIN * (2 ** FRAC_BITS));
    localparam logic signed [SUM_W-1:0] Y_HI = SUM_W'(Y_MAX * (2 ** FRAC_BITS));
    localparam logic signed [POS_W-1:0] X_RST = POS_W'(INIT_X * (2 ** FRAC_BITS));
    localparam logic signed [POS_W-1:0] Y_RST = POS_W'(INIT_Y * (2 ** FRAC_BITS));
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(FRICTION_PERIOD - 1);

    localparam logic signed [10:0] VEL_MOST_NEG = 11'sh400;
    localparam logic signed [10:0] VEL_SAT      = -11'sd1023;

    logic signed [POS_W-1:0] posx_q, posx_d, posy_q, posy_d;
    logic signed [10:0]      vx_q, vx_d, vy_q, vy_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    moving_q, moving_d;
    logic                    stopped_q, stopped_d;

    logic signed [SUM_W-1:0] sum_x, sum_y;
    logic signed [10:0]      vxf, vyf;
    logic signed [10:0]      sat_x, sat_y;
    logic                    fire;
    logic                    step;

    // Position candidates, friction-decayed velocity and saturated write values.
    always_comb begin
        sum_x = $signed({posx_q[POS_W-1], posx_q}) + $signed({{(SUM_W-11){vx_q[10]}}, vx_q});
        sum_y = $signed({posy_q[POS_W-1], posy_q}) + $signed({{(SUM_W-11){vy_q[10]}}, vy_q});
        fire  = (cnt_q == CNT_LAST);
        vxf   = vx_q;
        vyf   = vy_q;
        if (fire) begin
            if (vx_q > 11'sd0)      vxf = vx_q - 11'sd1;
            else if (vx_q < 11'sd0) vxf = vx_q + 11'sd1;
            if (vy_q > 11'sd0)      vyf = vy_q - 11'sd1;
            else if (vy_q < 11'sd0) vyf = vy_q + 11'sd1;
        end
        sat_x = (inVelocityX == VEL_MOST_NEG) ? VEL_SAT : inVelocityX;
        sat_y = (inVelocityY == VEL_MOST_NEG) ? VEL_SAT : inVelocityY;
        step  = startOfFrame && (moving_q || (vx_q != 11'sd0) || (vy_q != 11'sd0));
    end

    // Next-state selection: load > velocity write > frame step.
    always_comb begin
        posx_d = posx_q;
        posy_d = posy_q;
        vx_d   = vx_q;
        vy_d   = vy_q;
        cnt_d  = cnt_q;
        if (positionLoad) begin
            posx_d = {inPositionX, {FRAC_BITS{1'b0}}};
            posy_d = {inPositionY, {FRAC_BITS{1'b0}}};
            vx_d   = '0;
            vy_d   = '0;
            cnt_d  = '0;
        end else if (velocityWriteEnable) begin
            vx_d  = sat_x;
            vy_d  = sat_y;
            cnt_d = '0;
        end else if (step) begin
            cnt_d = fire ? '0 : cnt_q + CNT_W'(1);
            vx_d  = vxf;
            vy_d  = vyf;
            // Reflection negates the already friction-decayed component.
            if (sum_x < X_LO) begin
                posx_d = X_LO[POS_W-1:0];
                vx_d   = -vxf;
            end else if (sum_x > X_HI) begin
                posx_d = X_HI[POS_W-1:0];
                vx_d   = -vxf;
            end else begin
                posx_d = sum_x[POS_W-1:0];
            end
            if (sum_y < Y_LO) begin
                posy_d = Y_LO[POS_W-1:0];
                vy_d   = -vyf;
            end else if (sum_y > Y_HI) begin
                posy_d = Y_HI[POS_W-1:0];
                vy_d   = -vyf;
            end else begin
                posy_d = sum_y[POS_W-1:0];
            end
        end
        moving_d  = (vx_d != 11'sd0) || (vy_d != 11'sd0);
        stopped_d = moving_q && !moving_d;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            posx_q    <= X_RST;
            posy_q    <= Y_RST;
            vx_q      <= '0;
            vy_q      <= '0;
            cnt_q     <= '0;
            moving_q  <= 1'b0;
            stopped_q <= 1'b0;
        end else begin
            posx_q    <= posx_d;
            posy_q    <= posy_d;
            vx_q      <= vx_d;
            vy_q      <= vy_d;
            cnt_q     <= cnt_d;
            moving_q  <= moving_d;
            stopped_q <= stopped_d;
        end
    end

    assign topLeftX     = posx_q[POS_W-1:FRAC_BITS];
    assign topLeftY     = posy_q[POS_W-1:FRAC_BITS];
    assign velocityX    = vx_q;
    assign velocityY    = vy_q;
    assign moving       = moving_q;
    assign stoppedPulse = stopped_q;

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: two instances (friction period 4 and 1) share
// stimulus and are checked against an integer reference model.
module tb_ball_motion;

    localparam int XMIN = 32, XMAX = 592, YMIN = 32, YMAX = 432;
    localparam int ONE  = 64;

    logic clk = 1'b0;
    logic resetN;
    logic startOfFrame, velocityWriteEnable, positionLoad;
    logic signed [10:0] inVelocityX, inVelocityY, inPositionX, inPositionY;

    logic signed [10:0] tlxA, tlyA, vxA, vyA, tlxB, tlyB, vxB, vyB;
    logic movA, stpA, movB, stpB;
    logic [45:0] obs [2];

    int n_chk = 0;
    int n_bad = 0;

    // model state, index 0 = period 4, index 1 = period 1
    int m_px [2], m_py [2], m_vx [2], m_vy [2], m_cnt [2];
    bit m_mov [2], m_stp [2];

    always #5 clk = ~clk;

    ball_motion #(.FRICTION_PERIOD(4)) dutA (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .velocityWriteEnable(velocityWriteEnable),
        .inVelocityX(inVelocityX), .inVelocityY(inVelocityY),
        .positionLoad(positionLoad),
        .inPositionX(inPositionX), .inPositionY(inPositionY),
        .topLeftX(tlxA), .topLeftY(tlyA), .velocityX(vxA), .velocityY(vyA),
        .moving(movA), .stoppedPulse(stpA)
    );

    ball_motion #(.FRICTION_PERIOD(1)) dutB (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .velocityWriteEnable(velocityWriteEnable),
        .inVelocityX(inVelocityX), .inVelocityY(inVelocityY),
        .positionLoad(positionLoad),
        .inPositionX(inPositionX), .inPositionY(inPositionY),
        .topLeftX(tlxB), .topLeftY(tlyB), .velocityX(vxB), .velocityY(vyB),
        .moving(movB), .stoppedPulse(stpB)
    );

    assign obs[0] = {tlxA, tlyA, vxA, vyA, movA, stpA};
    assign obs[1] = {tlxB, tlyB, vxB, vyB, movB, stpB};

    function automatic int per_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic logic [45:0] exp_vec(input int k);
        return {11'(m_px[k] >>> 6), 11'(m_py[k] >>> 6), 11'(m_vx[k]), 11'(m_vy[k]),
                m_mov[k], m_stp[k]};
    endfunction

    function automatic int toward_zero(input int v);
        return (v > 0) ? v - 1 : (v < 0) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_px[k] = 320 * ONE; m_py[k] = 240 * ONE;
            m_vx[k] = 0; m_vy[k] = 0; m_cnt[k] = 0;
            m_mov[k] = 0; m_stp[k] = 0;
        end
    endtask

    task automatic model_step(input bit pl, input bit we, input bit sof,
                              input int ipx, input int ipy, input int ivx, input int ivy);
        for (int k = 0; k < 2; k++) begin
            bit was;
            int nx, ny;
            was = m_mov[k];
            if (pl) begin
                m_px[k] = ipx * ONE; m_py[k] = ipy * ONE;
                m_vx[k] = 0; m_vy[k] = 0; m_cnt[k] = 0;
            end else if (we) begin
                m_vx[k] = (ivx == -1024) ? -1023 : ivx;
                m_vy[k] = (ivy == -1024) ? -1023 : ivy;
                m_cnt[k] = 0;
            end else if (sof && (m_vx[k] != 0 || m_vy[k] != 0)) begin
                nx = m_px[k] + m_vx[k];
                ny = m_py[k] + m_vy[k];
                if (m_cnt[k] == per_of(k) - 1) begin
                    m_vx[k] = toward_zero(m_vx[k]);
                    m_vy[k] = toward_zero(m_vy[k]);
                    m_cnt[k] = 0;
                end else begin
                    m_cnt[k]++;
                end
                if (nx < XMIN * ONE)      begin m_px[k] = XMIN * ONE; m_vx[k] = -m_vx[k]; end
                else if (nx > XMAX * ONE) begin m_px[k] = XMAX * ONE; m_vx[k] = -m_vx[k]; end
                else m_px[k] = nx;
                if (ny < YMIN * ONE)      begin m_py[k] = YMIN * ONE; m_vy[k] = -m_vy[k]; end
                else if (ny > YMAX * ONE) begin m_py[k] = YMAX * ONE; m_vy[k] = -m_vy[k]; end
                else m_py[k] = ny;
            end
            m_mov[k] = (m_vx[k] != 0) || (m_vy[k] != 0);
            m_stp[k] = was && !m_mov[k];
        end
    endtask

    // One clock: drive at negedge, model at posedge, return at next negedge.
    task automatic tick(input bit pl, input bit we, input bit sof,
                        input int ipx, input int ipy, input int ivx, input int ivy);
        positionLoad        = pl;
        velocityWriteEnable = we;
        startOfFrame        = sof;
        inPositionX = 11'(ipx); inPositionY = 11'(ipy);
        inVelocityX = 11'(ivx); inVelocityY = 11'(ivy);
        @(posedge clk);
        model_step(pl, we, sof, ipx, ipy, ivx, ivy);
        @(negedge clk);
    endtask

    task automatic idle();
        tick(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        idle();
        model_reset();
        n_chk++;
        if (obs[0] !== {11'sd320, 11'sd240, 11'sd0, 11'sd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_held got=%h exp=%h", obs[0], {11'sd320, 11'sd240, 22'd0, 2'b00});
        end
        resetN = 1'b1;
        idle();
        idle();
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (obs[k] !== exp_vec(k)) begin
                n_bad++;
                $display("FAIL reset_release dut%0d got=%h exp=%h", k, obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_constant_motion();
        tick(0, 1, 0, 0, 0, 64, -32);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 1, 0, 0, 0, 0);
            idle();
        end
        n_chk++;
        if (tlxA !== 11'sd323 || tlyA !== 11'sd238 || movA !== 1'b1) begin
            n_bad++;
            $display("FAIL const_motion got x=%0d y=%0d mov=%b exp x=323 y=238 mov=1", tlxA, tlyA, movA);
        end
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (obs[k] !== exp_vec(k)) begin
                n_bad++;
                $display("FAIL const_motion_model dut%0d got=%h exp=%h", k, obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_friction_stop();
        logic signed [10:0] want [3];
        want[0] = 11'sd2; want[1] = 11'sd1; want[2] = 11'sd0;
        tick(1, 0, 0, 320, 240, 0, 0);
        tick(0, 1, 0, 0, 0, 3, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 1, 0, 0, 0, 0);
            n_chk++;
            if (vxB !== want[i] || stpB !== (i == 2)) begin
                n_bad++;
                $display("FAIL friction_step%0d got vx=%0d stp=%b exp vx=%0d stp=%b",
                         i, vxB, stpB, want[i], (i == 2));
            end
        end
        n_chk++;
        if (movB !== 1'b0 || tlxB !== 11'sd320) begin
            n_bad++;
            $display("FAIL friction_rest got mov=%b x=%0d exp mov=0 x=320", movB, tlxB);
        end
        idle();
        n_chk++;
        if (stpB !== 1'b0) begin
            n_bad++;
            $display("FAIL friction_pulse_len got stp=%b exp 0", stpB);
        end
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (obs[k] !== exp_vec(k)) begin
                n_bad++;
                $display("FAIL friction_model dut%0d got=%h exp=%h", k, obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_cushion();
        tick(1, 0, 0, 590, 100, 0, 0);
        tick(0, 1, 0, 0, 0, 256, 0);
        tick(0, 0, 1, 0, 0, 0, 0);
        n_chk++;
        if (tlxA !== 11'sd592 || vxA !== -11'sd256 || tlyA !== 11'sd100) begin
            n_bad++;
            $display("FAIL cushion_A got x=%0d vx=%0d y=%0d exp x=592 vx=-256 y=100", tlxA, vxA, tlyA);
        end
        n_chk++;
        if (tlxB !== 11'sd592 || vxB !== -11'sd255) begin
            n_bad++;
            $display("FAIL cushion_B got x=%0d vx=%0d exp x=592 vx=-255", tlxB, vxB);
        end
        // low-side reflection on both axes in one step
        tick(1, 0, 0, 33, 33, 0, 0);
        tick(0, 1, 0, 0, 0, -200, -200);
        tick(0, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (obs[k] !== exp_vec(k)) begin
                n_bad++;
                $display("FAIL cushion_low dut%0d got=%h exp=%h", k, obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_priority();
        tick(0, 1, 0, 0, 0, 100, 100);
        tick(1, 1, 1, 100, 200, 50, 50);
        n_chk++;
        if (obs[0] !== {11'sd100, 11'sd200, 11'sd0, 11'sd0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL priority_load got=%h exp=%h", obs[0],
                     {11'sd100, 11'sd200, 11'sd0, 11'sd0, 1'b0, 1'b1});
        end
        tick(0, 1, 1, 0, 0, -1024, -1024);
        n_chk++;
        if (vxA !== -11'sd1023 || vyA !== -11'sd1023 || tlxA !== 11'sd100 || tlyA !== 11'sd200) begin
            n_bad++;
            $display("FAIL priority_sat got vx=%0d vy=%0d x=%0d y=%0d exp -1023 -1023 100 200",
                     vxA, vyA, tlxA, tlyA);
        end
        tick(0, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (obs[k] !== exp_vec(k)) begin
                n_bad++;
                $display("FAIL priority_model dut%0d got=%h exp=%h", k, obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_back_to_back();
        tick(1, 0, 0, 320, 240, 0, 0);
        tick(0, 1, 0, 0, 0, 64, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 1, 0, 0, 0, 0);
        n_chk++;
        if (tlxA !== 11'sd324 || vxA !== 11'sd63) begin
            n_bad++;
            $display("FAIL back_to_back got x=%0d vx=%0d exp x=324 vx=63", tlxA, vxA);
        end
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (obs[k] !== exp_vec(k)) begin
                n_bad++;
                $display("FAIL back_to_back_model dut%0d got=%h exp=%h", k, obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_reset_midmotion();
        #2 resetN = 1'b0;
        #1;
        n_chk++;
        if (obs[0] !== {11'sd320, 11'sd240, 11'sd0, 11'sd0, 1'b0, 1'b0} ||
            obs[1] !== {11'sd320, 11'sd240, 11'sd0, 11'sd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL async_reset got A=%h B=%h exp=%h", obs[0], obs[1],
                     {11'sd320, 11'sd240, 24'd0});
        end
        @(negedge clk);
        n_chk++;
        if (stpA !== 1'b0 || stpB !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_no_pulse got A=%b B=%b exp 0 0", stpA, stpB);
        end
        model_reset();
        resetN = 1'b1;
        idle();
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (obs[k] !== exp_vec(k)) begin
                n_bad++;
                $display("FAIL reset_mid_model dut%0d got=%h exp=%h", k, obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            bit pl, we, sof;
            int px, py, vx, vy;
            pl  = ($urandom_range(31) == 0);
            we  = ($urandom_range(9) == 0);
            sof = ($urandom_range(3) == 0);
            if ($urandom_range(7) == 0) begin
                px = int'($urandom_range(2047)) - 1024;
                py = int'($urandom_range(2047)) - 1024;
            end else begin
                px = int'($urandom_range(639));
                py = int'($urandom_range(479));
            end
            if ($urandom_range(5) == 0) begin
                vx = int'($urandom_range(2047)) - 1024;
                vy = int'($urandom_range(2047)) - 1024;
            end else begin
                vx = int'($urandom_range(16)) - 8;
                vy = int'($urandom_range(600)) - 300;
            end
            tick(pl, we, sof, px, py, vx, vy);
            for (int k = 0; k < 2; k++) begin
                n_chk++;
                if (obs[k] !== exp_vec(k)) begin
                    n_bad++;
                    $display("FAIL random%0d dut%0d got=%h exp=%h", i, k, obs[k], exp_vec(k));
                end
            end
        end
    endtask

    initial begin
        resetN = 1'b0;
        startOfFrame = 1'b0; velocityWriteEnable = 1'b0; positionLoad = 1'b0;
        inVelocityX = '0; inVelocityY = '0; inPositionX = '0; inPositionY = '0;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_constant_motion();
        test_friction_stop();
        test_cushion();
        test_priority();
        test_back_to_back();
        test_reset_midmotion();
        test_random();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
